// File: rtl/hdsiso_ring.sv
`default_nettype none
// ============================================================================
// Module   : hdsiso_ring
// Purpose  : Serial-in/serial-out ring buffer of DEPTH entries. It replays the
//            input stream DEPTH shifts later and exposes a Gray-coded write
//            pointer and one-hot slot pulses for probing. It also contains a
//            Fibonacci PRBS generator with a period marker and a
//            self-synchronising PRBS checker with a saturating error counter.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module hdsiso_ring #(
  parameter int              DEPTH = 8,
  parameter int              AW    = $clog2(DEPTH),
  parameter int              LW    = 8,
  parameter logic [LW-1:0]   TAPS  = LW'(8'hB8),
  parameter logic [LW-1:0]   SEED  = LW'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             d_in,
  input  logic             din_sel,
  input  logic             lfsr_en,
  output logic             d_out,
  output logic [AW-1:0]    gray,
  output logic [DEPTH-1:0] pulse,
  output logic             lfsr_bit,
  output logic             lfsr_period,
  output logic [1:0]       chk_state,
  output logic [7:0]       err_cnt
);

  // Checker counter must reach DEPTH (up to 64) and LW-1 (up to 15).
  localparam int CW = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SYNC  = 2'd2,
    ST_CHECK = 2'd3
  } chk_state_t;

  // Ring storage and pointer
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    wp_d;
  logic             dout_q;
  logic             ring_in;

  // PRBS generator
  logic [LW-1:0]    lfsr_q;
  logic [LW-1:0]    lfsr_d;

  // PRBS checker
  chk_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [LW-1:0]    ref_q;
  logic [7:0]       err_q;
  logic             exp_bit;

  // Next-state values for the ring pointer, generator and checker prediction
  always_comb begin
    ring_in = din_sel ? lfsr_q[LW-1] : d_in;
    wp_d    = wp_q + AW'(1);
    lfsr_d  = {lfsr_q[LW-2:0], ^(lfsr_q & TAPS)};
    exp_bit = ^(ref_q & TAPS);
  end

  // Ring: read the slot at wp before overwriting it, then advance the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      dout_q <= 1'b0;
      wp_q   <= '0;
    end else if (shift_en) begin
      dout_q      <= mem_q[wp_q];
      mem_q[wp_q] <= ring_in;
      wp_q        <= wp_d;
    end
  end

  // Fibonacci LFSR; only advances when both enables are high, never reloads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (shift_en && lfsr_en) begin
      lfsr_q <= lfsr_d;
    end
  end

  // Checker FSM: wait for the first PRBS bit to come around the ring, load
  // LW received bits as the reference, then compare against self-predicted
  // bits. Predicted (not received) bits feed the reference so a single bad
  // bit does not corrupt later predictions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ref_q   <= '0;
      err_q   <= '0;
    end else if (!din_sel) begin
      // Leaving PRBS mode aborts the checker immediately; the error count
      // stays visible until the next run starts.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (shift_en) begin
      case (state_q)
        ST_IDLE: begin
          // This edge already writes the first PRBS bit, so it counts as one.
          state_q <= ST_FILL;
          cnt_q   <= CW'(1);
          err_q   <= '0;
        end
        ST_FILL: begin
          // After DEPTH+1 edges the first PRBS bit sits on d_out.
          if (cnt_q == CW'(DEPTH)) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SYNC: begin
          ref_q <= {ref_q[LW-2:0], dout_q};
          if (cnt_q == CW'(LW - 1)) begin
            state_q <= ST_CHECK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_CHECK: begin
          if ((dout_q != exp_bit) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
          end
          ref_q <= {ref_q[LW-2:0], exp_bit};
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // One-hot slot pulses decoded from the binary write pointer
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_pulse
      assign pulse[i] = (wp_q == AW'(i));
    end
  endgenerate

  assign d_out       = dout_q;
  assign gray        = wp_q ^ (wp_q >> 1);
  assign lfsr_bit    = lfsr_q[LW-1];
  assign lfsr_period = (lfsr_q == SEED);
  assign chk_state   = state_q;
  assign err_cnt     = err_q;

endmodule
`default_nettype wire
